// File: rtl/btn_ctrl.sv
// btn_ctrl: push-button debounce and event controller.
//
// Raw pad levels are brought into the clk domain through a two-flop
// synchronizer. One prescaled sample tick is shared round-robin across the
// buttons. A button's debounced level only flips after STABLE_CNT
// consecutive services that disagree with it. Each accepted change produces
// a one-cycle press/release pulse. Presses latch into a sticky
// interrupt-pending register.
//
// Ports:
//   clk            core clock
//   rst            asynchronous, active-high reset
//   btn_i          raw button levels from the pads (async, 1 = pressed)
//   btn_o          debounced levels
//   press_o        one-cycle pulse on a debounced 0->1 change
//   release_o      one-cycle pulse on a debounced 1->0 change
//   irq_mask_i     per-button interrupt enable
//   irq_clr_i      write-1-to-clear for pending bits (sampled every cycle)
//   irq_pending_o  sticky press-pending flags
//   irq_o          OR of pending bits that are enabled by irq_mask_i

module btn_ctrl #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    input  logic [N_BTN-1:0] irq_mask_i,
    input  logic [N_BTN-1:0] irq_clr_i,
    output logic [N_BTN-1:0] irq_pending_o,
    output logic             irq_o
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int PTR_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync;
    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt [N_BTN];

    // Two-flop synchronizer for the asynchronous pad levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_i;
            sync      <= sync_meta;
        end
    end

    // Sample prescaler: tick is high during the last cycle of each period.
    assign tick = (pre == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Round-robin service pointer, advances once per tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (tick) begin
            if (ptr == PTR_W'(N_BTN - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

    // Per-button debounce. Only the button under the pointer is touched on
    // a tick, so at most one level (and one event pulse) changes per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
            btn_o     <= '0;
            press_o   <= '0;
            release_o <= '0;
        end else begin
            press_o   <= '0;
            release_o <= '0;
            if (tick) begin
                for (int unsigned i = 0; i < N_BTN; i++) begin
                    if (ptr == PTR_W'(i)) begin
                        if (sync[i] == btn_o[i]) begin
                            // Agreeing sample: any partial qualification is discarded.
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_W'(STABLE_CNT - 1)) begin
                            btn_o[i]     <= sync[i];
                            cnt[i]       <= '0;
                            press_o[i]   <= sync[i];
                            release_o[i] <= ~sync[i];
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Sticky pending: a press in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pending_o <= '0;
        end else begin
            irq_pending_o <= (irq_pending_o & ~irq_clr_i) | press_o;
        end
    end

    assign irq_o = |(irq_pending_o & irq_mask_i);

endmodule

// File: tb/tb_btn_ctrl.sv
// tb_btn_ctrl: self-checking bench for btn_ctrl with N_BTN=4, TICK_DIV=4,
// STABLE_CNT=3. A behavioural reference model derives the sample schedule
// from the number of clocks elapsed since reset and counts consecutive
// disagreeing samples per button.

module tb_btn_ctrl;

    localparam int N_BTN      = 4;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn_i;
    logic [N_BTN-1:0] btn_o;
    logic [N_BTN-1:0] press_o;
    logic [N_BTN-1:0] release_o;
    logic [N_BTN-1:0] irq_mask_i;
    logic [N_BTN-1:0] irq_clr_i;
    logic [N_BTN-1:0] irq_pending_o;
    logic             irq_o;

    int checks = 0;
    int errors = 0;

    btn_ctrl #(
        .N_BTN      (N_BTN),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_i         (btn_i),
        .btn_o         (btn_o),
        .press_o       (press_o),
        .release_o     (release_o),
        .irq_mask_i    (irq_mask_i),
        .irq_clr_i     (irq_clr_i),
        .irq_pending_o (irq_pending_o),
        .irq_o         (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int               m_k;
    logic [N_BTN-1:0] m_s1, m_s2;
    logic [N_BTN-1:0] m_lvl, m_press, m_rel, m_pend;
    int               m_streak [N_BTN];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = 0;
            m_s1 = '0; m_s2 = '0;
            m_lvl = '0; m_press = '0; m_rel = '0; m_pend = '0;
            for (int b = 0; b < N_BTN; b++) m_streak[b] = 0;
        end else begin
            m_pend  = (m_pend & ~irq_clr_i) | m_press;
            m_press = '0;
            m_rel   = '0;
            if ((m_k % TICK_DIV) == TICK_DIV - 1) begin
                int b;
                b = (m_k / TICK_DIV) % N_BTN;
                if (m_s2[b] != m_lvl[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == STABLE_CNT) begin
                        m_lvl[b]   = m_s2[b];
                        m_press[b] = m_s2[b];
                        m_rel[b]   = ~m_s2[b];
                        m_streak[b] = 0;
                    end
                end else begin
                    m_streak[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_i;
            m_k++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        btn_i     = '0;
        irq_clr_i = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; btn_i = '0; irq_mask_i = '0; irq_clr_i = '0;
        #2;
        rst = 1'b1; btn_i = 4'hF; irq_mask_i = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({btn_o, press_o, release_o, irq_pending_o, irq_o} !== 17'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b, want all zero", c,
                         {btn_o, press_o, release_o, irq_pending_o, irq_o});
            end
        end
        rst = 1'b0;
        btn_i = 4'b0001;
        // First tick 3 cycles after release serves button 0, so the third
        // qualifying service lands on edge 35 and is visible at negedge 36.
        for (int n = 1; n <= 38; n++) begin
            @(negedge clk);
            checks++;
            if ({btn_o, press_o, release_o, irq_pending_o, irq_o} !==
                {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)}) begin
                errors++;
                $display("FAIL reset_model cycle %0d: got %b, want %b", n,
                         {btn_o, press_o, release_o, irq_pending_o, irq_o},
                         {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)});
            end
            if (n == 35) begin
                checks++;
                if (btn_o !== 4'b0000) begin
                    errors++;
                    $display("FAIL first_tick_early: btn_o=%b, want 0000", btn_o);
                end
            end
            if (n == 36) begin
                checks++;
                if (btn_o !== 4'b0001 || press_o !== 4'b0001) begin
                    errors++;
                    $display("FAIL first_tick_rise: btn_o=%b press_o=%b, want 0001/0001",
                             btn_o, press_o);
                end
            end
            if (n == 37) begin
                checks++;
                if (irq_pending_o !== 4'b0001 || irq_o !== 1'b1 || press_o !== 4'b0000) begin
                    errors++;
                    $display("FAIL first_tick_pending: pend=%b irq=%b press=%b, want 0001/1/0000",
                             irq_pending_o, irq_o, press_o);
                end
            end
        end
    endtask

    task automatic test_clean_press();
        int rise = -1;
        logic [N_BTN-1:0] press_at_rise, press_after, pend_after;
        logic irq_after;
        int presses = 0;
        press_at_rise = '0; press_after = 'x; pend_after = 'x; irq_after = 1'bx;
        do_reset();
        irq_mask_i = 4'b0100;
        btn_i      = 4'b0100;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            checks++;
            if ({btn_o, press_o, release_o, irq_pending_o, irq_o} !==
                {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)}) begin
                errors++;
                $display("FAIL press_model cycle %0d: got %b, want %b", n,
                         {btn_o, press_o, release_o, irq_pending_o, irq_o},
                         {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)});
            end
            if (press_o != 0) presses++;
            if (rise < 0 && btn_o[2] === 1'b1) begin
                rise = n;
                press_at_rise = press_o;
            end else if (rise > 0 && n == rise + 1) begin
                press_after = press_o;
                pend_after  = irq_pending_o;
                irq_after   = irq_o;
            end
        end
        checks++;
        if (rise < 1 || rise > 51) begin
            errors++;
            $display("FAIL press_latency: rise at cycle %0d, want 1..51", rise);
        end
        checks++;
        if (press_at_rise !== 4'b0100 || presses != 1) begin
            errors++;
            $display("FAIL press_pulse: press_o=%b count=%0d, want 0100 once", press_at_rise, presses);
        end
        checks++;
        if (press_after !== 4'b0000 || pend_after !== 4'b0100 || irq_after !== 1'b1) begin
            errors++;
            $display("FAIL press_pending: press=%b pend=%b irq=%b, want 0000/0100/1",
                     press_after, pend_after, irq_after);
        end
        irq_mask_i = 4'b0000;
        #1;
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL press_masked: irq_o=%b, want 0", irq_o);
        end
        irq_mask_i = 4'b0100;
    endtask

    task automatic test_release();
        int rels = 0;
        logic [N_BTN-1:0] rel_val;
        rel_val = '0;
        btn_i = 4'b0000;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            checks++;
            if ({btn_o, press_o, release_o, irq_pending_o, irq_o} !==
                {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)}) begin
                errors++;
                $display("FAIL release_model cycle %0d: got %b, want %b", n,
                         {btn_o, press_o, release_o, irq_pending_o, irq_o},
                         {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)});
            end
            if (release_o != 0) begin
                rels++;
                rel_val = release_o;
            end
        end
        checks++;
        if (rels != 1 || rel_val !== 4'b0100) begin
            errors++;
            $display("FAIL release_pulse: count=%0d value=%b, want 1 x 0100", rels, rel_val);
        end
        checks++;
        if (btn_o !== 4'b0000 || irq_pending_o !== 4'b0100) begin
            errors++;
            $display("FAIL release_state: btn_o=%b pend=%b, want 0000/0100", btn_o, irq_pending_o);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        irq_mask_i = 4'b0000;
        btn_i      = 4'b0010;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            checks++;
            if ({btn_o, press_o, irq_pending_o} !== 12'b0 ||
                {btn_o, press_o, release_o, irq_pending_o} !== {m_lvl, m_press, m_rel, m_pend}) begin
                errors++;
                $display("FAIL glitch cycle %0d: btn=%b press=%b pend=%b, want all 0",
                         n, btn_o, press_o, irq_pending_o);
            end
            if (n == 20) btn_i = 4'b0000;
        end
    endtask

    task automatic test_clear_vs_set();
        bit hit = 0;
        do_reset();
        irq_mask_i = 4'b0001;
        btn_i      = 4'b0001;
        for (int n = 1; n <= 60 && !hit; n++) begin
            @(negedge clk);
            if (m_press[0]) begin
                hit = 1;
                irq_clr_i = 4'b0001;
                @(negedge clk);
                irq_clr_i = 4'b0000;
                checks++;
                if (irq_pending_o[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_vs_set: pending[0]=%b, want 1", irq_pending_o[0]);
                end
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL clear_vs_set_timeout: no press on button 0 within 60 cycles, want one");
        end
        repeat (5) @(negedge clk);
        checks++;
        if (irq_pending_o !== 4'b0001 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL pending_sticky: pend=%b irq=%b, want 0001/1", irq_pending_o, irq_o);
        end
        irq_clr_i = 4'b0001;
        @(negedge clk);
        irq_clr_i = 4'b0000;
        checks++;
        if (irq_pending_o !== 4'b0000 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL lone_clear: pend=%b irq=%b, want 0000/0", irq_pending_o, irq_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        irq_mask_i = 4'b0001;
        btn_i      = 4'b1001;
        // Button 0 qualifies by cycle 36; button 3 has had two services by cycle 41.
        repeat (41) @(negedge clk);
        checks++;
        if (btn_o !== 4'b0001 || irq_pending_o !== 4'b0001 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: btn=%b pend=%b irq=%b, want 0001/0001/1",
                     btn_o, irq_pending_o, irq_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({btn_o, press_o, release_o, irq_pending_o, irq_o} !== 17'b0) begin
            errors++;
            $display("FAIL async_clear: got %b, want all zero",
                     {btn_o, press_o, release_o, irq_pending_o, irq_o});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            checks++;
            if ({btn_o, press_o, release_o, irq_pending_o, irq_o} !==
                {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)}) begin
                errors++;
                $display("FAIL async_model cycle %0d: got %b, want %b", n,
                         {btn_o, press_o, release_o, irq_pending_o, irq_o},
                         {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)});
            end
            if (n == 47 || n == 48) begin
                checks++;
                if (btn_o[3] !== (n == 48)) begin
                    errors++;
                    $display("FAIL async_requalify cycle %0d: btn_o[3]=%b, want %0d",
                             n, btn_o[3], (n == 48));
                end
            end
        end
    endtask

    task automatic test_random();
        int hold [N_BTN];
        do_reset();
        for (int b = 0; b < N_BTN; b++) hold[b] = 0;
        irq_mask_i = 4'($urandom);
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            checks++;
            if ({btn_o, press_o, release_o, irq_pending_o, irq_o} !==
                {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)}) begin
                errors++;
                $display("FAIL random_model cycle %0d: got %b, want %b", n,
                         {btn_o, press_o, release_o, irq_pending_o, irq_o},
                         {m_lvl, m_press, m_rel, m_pend, |(m_pend & irq_mask_i)});
            end
            checks++;
            if ($countones(press_o | release_o) > 1) begin
                errors++;
                $display("FAIL random_onehot cycle %0d: events=%b, want at most one bit",
                         n, press_o | release_o);
            end
            for (int b = 0; b < N_BTN; b++) begin
                if (hold[b] == 0) begin
                    btn_i[b] = ~btn_i[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12)
                                                          : $urandom_range(20, 80);
                end else begin
                    hold[b]--;
                end
            end
            irq_clr_i = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if (n % 100 == 0) irq_mask_i = 4'($urandom);
        end
        irq_clr_i = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_glitch();
        test_clear_vs_set();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_ctrl.md
# btn_ctrl

Debounce and event controller for the push-button inputs arriving from the input pad ring. It synchronizes the raw pad-side button levels into the core clock domain and time-shares one sampling scheduler across all buttons to debounce them. It produces clean levels, single-cycle press/release events and a maskable, sticky interrupt-pending register for the CPU peripheral bus. It sits between the input pad cells and the GPIO/interrupt peripheral.

## Interface

- N_BTN, 4, number of buttons (≥1)
- TICK_DIV, 50000, clk cycles per sample tick (≥2)
- STABLE_CNT, 4, consecutive disagreeing samples needed to accept a new level (≥1)
- clk  input  1  core clock
- rst  input  1  reset; asynchronous and active-high
- btn_i  input  N_BTN  raw button levels from the pads, asynchronous; 1 = pressed
- btn_o  output  N_BTN  debounced level
- press_o  output  N_BTN  one-cycle pulse when btn_o[i] goes 0→1
- release_o  output  N_BTN  one-cycle pulse when btn_o[i] goes 1→0
- irq_mask_i  input  N_BTN  interrupt enable per button
- irq_clr_i  input  N_BTN  write-1-to-clear for pending bits, sampled every cycle
- irq_pending_o  output  N_BTN  sticky press-pending flags
- irq_o  output  1  |(irq_pending_o & irq_mask_i), combinational from registered pending

## Operation

- Synchronizer: two flops per bit on btn_i → sync[i]; reset 0.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0. Internal tick = 1 in the cycle the counter equals TICK_DIV-1.
- Scheduler: round-robin pointer ptr, 0..N_BTN-1, reset 0. Advances by 1 on every tick and wraps N_BTN-1→0. Only button ptr is serviced on a tick.
- Per-button state cnt[i], width clog2(STABLE_CNT+1), reset 0. On a tick serving button i:
  - If sync[i]==btn_o[i]: cnt[i]←0.
  - Else if cnt[i]==STABLE_CNT-1: btn_o[i]←sync[i], cnt[i]←0, and press_o[i] or release_o[i] is set for exactly the next cycle.
  - Else: cnt[i]←cnt[i]+1.
- Unserviced buttons keep their cnt and btn_o unchanged.
- A single disagreeing-then-agreeing service resets the count, so glitches shorter than one service interval are rejected.
- Pending: pending[i] is set by press_o[i] and cleared by irq_clr_i[i]. When set and clear coincide in the same cycle, set wins. Release events never touch pending.
- Masking affects irq_o only. Pending bits latch regardless of mask.
- At most one button changes per clock, so at most one press_o/release_o bit is high in any cycle.
- Reset (asynchronous, any time, including mid-count): all flops return to their reset values immediately. The prescaler restarts from 0 on deassertion.

## Timing

- Reset values: btn_o=0, press_o=0, release_o=0, irq_pending_o=0, irq_o=0. Internal ptr, cnt and prescaler are all 0.
- First tick occurs TICK_DIV-1 cycles after reset deassertion, serving button 0.
- Button i is serviced once every N_BTN×TICK_DIV cycles.
- Input-to-btn_o latency for a stable change, including 2 synchronizer cycles:
  - Minimum: (STABLE_CNT-1)×N_BTN×TICK_DIV + 3 cycles.
  - Maximum: STABLE_CNT×N_BTN×TICK_DIV + 3 cycles.
- press_o/release_o are registered and go high in the same cycle btn_o changes. Width is exactly 1 cycle.
- irq_pending_o rises 1 cycle after press_o. irq_o follows combinationally.
- irq_clr_i takes effect on irq_pending_o the following cycle.

## Test plan

All scenarios use N_BTN=4, TICK_DIV=4, STABLE_CNT=3 (service interval 16 cycles).

1. Reset: hold rst for 5 cycles with btn_i=4'hF → all outputs 0 during reset. First tick occurs 3 cycles after release.
2. Clean press: raise btn_i[2] and hold → btn_o[2]=1 within 51 cycles; press_o=4'b0100 for exactly 1 cycle; irq_pending_o[2]=1 next cycle; irq_o=1 when irq_mask_i=4'b0100 and 0 when the mask is 4'b0000.
3. Glitch rejection: btn_i[1] high for 20 cycles, then low → btn_o, press_o and irq_pending_o all stay 0.
4. Release: from the debounced pressed state of scenario 2, drop btn_i[2] → release_o[2] pulses once, btn_o[2]=0, irq_pending_o[2] stays 1.
5. Clear vs set: assert irq_clr_i[0] in the same cycle press_o[0] pulses → irq_pending_o[0]=1. A lone clear pulse on a later cycle → 0 the following cycle.
6. Async reset mid-count: two services into a btn_i[3] press, assert rst for 1 cycle → all state clears at once. After release, a full 3-service qualification is needed before btn_o[3]=1.
